// File: rtl/board_stream_tx.sv
`default_nettype none
// ============================================================================
// board_stream_tx : snapshots the packed 16x16-bit board and streams one
//                   {tile index, log2 exponent} byte per tile over valid/ready.
// Option macro    : BOARD_STREAM_CSUM_EN appends an XOR-of-exponents record.
// Revision        : 1.0
// ============================================================================
module board_stream_tx (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [0:255] board_in,
   input  logic         frame_req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic         out_csum,
   output logic         busy,
   output logic         bad_tile
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SEND     = 2'd1;
   localparam logic [1:0] WAIT_GAP = 2'd2;

   logic [1:0]   state_q,    state_d;
   logic [0:255] snap_q,     snap_d;
   logic [3:0]   cnt_q,      cnt_d;
   logic         pending_q,  pending_d;
   logic         bad_tile_q, bad_tile_d;
`ifdef BOARD_STREAM_CSUM_EN
   logic         csum_phase_q, csum_phase_d;
   logic [3:0]   exp_xor;
`endif

   logic [3:0]   tile_exp [16];
   logic [15:0]  tile_bad;
   logic         changed;
   logic         capture;
   logic         xfer;

   function automatic logic [3:0] log2_exp(input logic [15:0] v);
      logic [3:0] e;
      e = 4'd0;
      for (int k = 1; k < 16; k++) begin
         if (v == (16'd1 << k)) e = 4'(k);
      end
      return e;
   endfunction

   // 1 is a power of two but not a legal tile value
   function automatic logic is_bad(input logic [15:0] v);
      return (v == 16'd1) || ((v & (v - 16'd1)) != 16'd0);
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_tile
      assign tile_exp[i] = log2_exp(snap_q[i*16 +: 16]);
      assign tile_bad[i] = is_bad(board_in[i*16 +: 16]);
   end

`ifdef BOARD_STREAM_CSUM_EN
   always_comb begin
      exp_xor = 4'd0;
      for (int i = 0; i < 16; i++) exp_xor = exp_xor ^ tile_exp[i];
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         snap_q       <= '0;
         cnt_q        <= 4'd0;
         pending_q    <= 1'b0;
         bad_tile_q   <= 1'b0;
`ifdef BOARD_STREAM_CSUM_EN
         csum_phase_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         bad_tile_q   <= bad_tile_d;
`ifdef BOARD_STREAM_CSUM_EN
         csum_phase_q <= csum_phase_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      cnt_d        = cnt_q;
      pending_d    = pending_q;
      bad_tile_d   = bad_tile_q;
`ifdef BOARD_STREAM_CSUM_EN
      csum_phase_d = csum_phase_q;
`endif
      changed      = (board_in != snap_q) || frame_req;
      xfer         = (state_q == SEND) && out_ready;
      capture      = 1'b0;

      case (state_q)
         IDLE: begin
            if (changed || pending_q) capture = 1'b1;
         end
         SEND: begin
            if (changed) pending_d = 1'b1;
            if (xfer) begin
`ifdef BOARD_STREAM_CSUM_EN
               if (csum_phase_q) begin
                  csum_phase_d = 1'b0;
                  state_d      = WAIT_GAP;
               end else if (cnt_q == 4'd15) begin
                  csum_phase_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
`else
               if (cnt_q == 4'd15) state_d = WAIT_GAP;
               else                cnt_d   = cnt_q + 4'd1;
`endif
            end
         end
         WAIT_GAP: begin
            cnt_d = 4'd0;
            // A request seen during the frame restarts right after the gap
            if (pending_q) begin
               capture = 1'b1;
            end else begin
               state_d   = IDLE;
               pending_d = changed;
            end
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         snap_d       = board_in;
         cnt_d        = 4'd0;
         pending_d    = 1'b0;
         state_d      = SEND;
         bad_tile_d   = bad_tile_q | (|tile_bad);
`ifdef BOARD_STREAM_CSUM_EN
         csum_phase_d = 1'b0;
`endif
      end
   end

   always_comb begin
      out_valid = (state_q == SEND);
      busy      = (state_q != IDLE);
      bad_tile  = bad_tile_q;
      out_data  = 8'h00;
      out_last  = 1'b0;
      out_csum  = 1'b0;
      if (state_q == SEND) begin
         out_data = {cnt_q, tile_exp[cnt_q]};
`ifdef BOARD_STREAM_CSUM_EN
         if (csum_phase_q) begin
            out_data = {4'h0, exp_xor};
            out_last = 1'b1;
            out_csum = 1'b1;
         end
`else
         out_last = (cnt_q == 4'd15);
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_board_stream_tx.sv
`default_nettype none
// ============================================================================
// tb_board_stream_tx : directed self-checking bench for board_stream_tx.
// Revision           : 1.0
// ============================================================================
module tb_board_stream_tx;

`ifdef BOARD_STREAM_CSUM_EN
   localparam int NREC = 17;
`else
   localparam int NREC = 16;
`endif

   logic         clk;
   logic         rst_n;
   logic [0:255] board_in;
   logic         frame_req;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic         out_csum;
   logic         busy;
   logic         bad_tile;

   int           checks;
   int           errors;
   logic [3:0]   exp_cur [16];
   logic [0:255] board_a;
   logic [0:255] board_b;
   logic [0:255] board_c;

   board_stream_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .board_in  (board_in),
      .frame_req (frame_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_csum  (out_csum),
      .busy      (busy),
      .bad_tile  (bad_tile)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_exp_a();
      for (int i = 0; i < 16; i++) exp_cur[i] = 4'd0;
      exp_cur[0] = 4'd1;
      exp_cur[5] = 4'd11;
   endtask

   task automatic set_exp_b();
      for (int i = 0; i < 16; i++) exp_cur[i] = 4'd0;
      exp_cur[3]  = 4'd4;
      exp_cur[15] = 4'd15;
   endtask

   task automatic check_record(input int idx);
      logic [3:0] iv;
      logic [3:0] x;
      logic       last_exp;
      iv = idx[3:0];
      check("rec_valid", 32'(out_valid), 32'd1);
      check("rec_busy", 32'(busy), 32'd1);
      if (idx < 16) begin
`ifdef BOARD_STREAM_CSUM_EN
         last_exp = 1'b0;
`else
         last_exp = (idx == 15);
`endif
         check("rec_data", 32'(out_data), 32'({iv, exp_cur[idx]}));
         check("rec_last", 32'(out_last), 32'(last_exp));
         check("rec_csum", 32'(out_csum), 32'd0);
      end else begin
         x = 4'd0;
         for (int i = 0; i < 16; i++) x = x ^ exp_cur[i];
         check("csum_data", 32'(out_data), 32'({4'h0, x}));
         check("csum_last", 32'(out_last), 32'd1);
         check("csum_flag", 32'(out_csum), 32'd1);
      end
   endtask

   task automatic run_frame(input int start);
      for (int i = start; i < NREC; i++) begin
         check_record(i);
         step();
      end
   endtask

   task automatic check_gap_then_idle();
      check("gap_valid", 32'(out_valid), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      step();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int         idx;
      int         c;
      logic [3:0] pat;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      board_in  = '0;
      frame_req = 1'b0;
      out_ready = 1'b1;
      pat       = 4'b1001;

      board_a = '0;
      board_a[0*16 +: 16] = 16'd2;
      board_a[5*16 +: 16] = 16'd2048;
      board_b = '0;
      board_b[3*16 +: 16]  = 16'd16;
      board_b[15*16 +: 16] = 16'd32768;
      board_c = '0;
      board_c[2*16 +: 16] = 16'd3;

      // Reset values
      step(); step(); step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_csum", 32'(out_csum), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bad", 32'(bad_tile), 32'd0);

      // All-zero board after reset release: no frame
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         check("zero_board_quiet", 32'(out_valid), 32'd0);
      end

      // Board A: valid one cycle after the change
      board_in = board_a;
      set_exp_a();
      step();
      run_frame(0);
      check_gap_then_idle();

      // Stall pattern 1-0-0-1 on a requested resend
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      idx = 0;
      c   = 0;
      while (idx < NREC && c < 200) begin
         out_ready = pat[c % 4];
         check_record(idx);
         step();
         if (out_ready) idx++;
         c++;
      end
      out_ready = 1'b1;
      check("stall_transfers", 32'(idx), 32'(NREC));
      check_gap_then_idle();

      // Mid-frame change: old frame completes, new one after a single gap cycle
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_record(i);
         step();
      end
      board_in = board_b;
      run_frame(4);
      check("mid_gap_valid", 32'(out_valid), 32'd0);
      check("mid_gap_busy", 32'(busy), 32'd1);
      step();
      set_exp_b();
      run_frame(0);
      check_gap_then_idle();
      step();

      // Illegal tile value 3
      board_in = board_c;
      for (int i = 0; i < 16; i++) exp_cur[i] = 4'd0;
      step();
      check("bad_after_capture", 32'(bad_tile), 32'd1);
      run_frame(0);
      check_gap_then_idle();
      board_in = board_a;
      set_exp_a();
      step();
      run_frame(0);
      check("bad_sticky", 32'(bad_tile), 32'd1);
      check_gap_then_idle();

      // Reset during record 7, then full resend from index 0
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check_record(i);
         step();
      end
      check_record(7);
      rst_n = 1'b0;
      step();
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_last", 32'(out_last), 32'd0);
      check("midrst_bad", 32'(bad_tile), 32'd0);
      rst_n = 1'b1;
      step();
      run_frame(0);
      check_gap_then_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
